prn_arbiter: RTL and testbench

- Owns one 8-bit Fibonacci LFSR and shares it between NREQ requesters.
- Handles seeding, with a zero-seed guard, and a warm-up run after every (re)seed.
- Arbitrates requesters round-robin; each grant delivers one pseudo-random byte and advances the LFSR one step.
- Sits between the PRN datapath and its consumers (scramblers, test-pattern generators), so no consumer drives the shift register directly.

---
 rtl/prn_pkg.sv | 9 +
 rtl/prn_arbiter_lfsr8_core.sv | 20 ++
 rtl/prn_arbiter.sv | 81 ++++++++
 tb/tb_prn_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/prn_pkg.sv
// prn_pkg: shared types, constants and LFSR step function for the PRN arbiter slice.
package prn_pkg;
    typedef enum logic [0:0] {WARM = 1'b0, READY = 1'b1} state_e;
    localparam logic [7:0] TAPS_MAX8      = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED_C = 8'h01;
    function automatic logic [7:0] lfsr_step(input logic [7:0] q, input logic [7:0] taps);
        return {q[6:0], ^(q & taps)};
    endfunction
endpackage

// File: rtl/prn_arbiter_lfsr8_core.sv
// lfsr8_core: 8-bit Fibonacci LFSR register with load (priority) and step controls.
module lfsr8_core import prn_pkg::*; #(
    parameter logic [7:0] TAPS    = TAPS_MAX8,
    parameter logic [7:0] RST_VAL = DEFAULT_SEED_C
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       step,
    output logic [7:0] q
);
    logic [7:0] q_q, q_d;
    always_comb q_d = load ? load_val : step ? lfsr_step(q_q, TAPS) : q_q;
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) q_q <= RST_VAL;
        else       q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/prn_arbiter.sv
// prn_arbiter: shares one LFSR among NREQ requesters round-robin, with seeding, warm-up and lockup recovery.
module prn_arbiter import prn_pkg::*; #(
    parameter int         NREQ         = 4,
    parameter logic [7:0] TAPS         = TAPS_MAX8,
    parameter logic [7:0] DEFAULT_SEED = DEFAULT_SEED_C,
    parameter int         WARMUP       = 4
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic            seed_valid,
    input  logic [7:0]      seed_data,
    output logic            seed_ready,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [7:0]      rnd_data,
    output logic            busy,
    output logic            stuck_err
);
    localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int PW = $clog2(NREQ);
    state_e          state_q, state_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, win, cand;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [7:0]      rnd_q, rnd_d, lfsr, load_val;
    logic            stuck_q, stuck_d, lock, warm, seed_hs, grant, load, step;

    lfsr8_core #(.TAPS(TAPS), .RST_VAL(DEFAULT_SEED)) u_lfsr (
        .clk(clk), .rst_(rst_), .load(load), .load_val(load_val), .step(step), .q(lfsr)
    );

    // Scan downward so the last hit is the one closest to rr_ptr.
    always_comb begin
        win  = '0;
        cand = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = PW'((int'(rr_ptr_q) + i) % NREQ);
            if (req[cand]) win = cand;
        end
    end

    always_comb begin
        lock     = (lfsr == 8'h00);
        warm     = (state_q == WARM);
        seed_hs  = !warm && seed_valid;
        grant    = !warm && !seed_valid && (|req) && !lock;
        load     = lock || seed_hs;
        load_val = (lock || seed_data == 8'h00) ? DEFAULT_SEED : seed_data;
        step     = !lock && ((warm && wcnt_q != '0) || grant);
        state_d  = lock ? state_q : seed_hs ? WARM : (warm && wcnt_q == '0) ? READY : state_q;
        wcnt_d   = lock ? wcnt_q : seed_hs ? WW'(WARMUP) : (warm && wcnt_q != '0) ? wcnt_q - WW'(1) : wcnt_q;
        stuck_d  = lock || (seed_hs && seed_data == 8'h00);
        gnt_d    = grant ? NREQ'(1) << win : '0;
        rnd_d    = grant ? lfsr : rnd_q;
        rr_ptr_d = !grant ? rr_ptr_q : (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= WARM;
            wcnt_q   <= WW'(WARMUP);
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            rnd_q    <= 8'h00;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            rnd_q    <= rnd_d;
            stuck_q  <= stuck_d;
        end
    end

    assign gnt        = gnt_q;
    assign rnd_data   = rnd_q;
    assign stuck_err  = stuck_q;
    assign busy       = (state_q == WARM);
    assign seed_ready = (state_q == READY);
endmodule

// File: tb/tb_prn_arbiter.sv
// tb_prn_arbiter: directed bench with a cycle model for the default instance plus literal-pinned checks.
module tb_prn_arbiter;
    logic clk = 1'b0, rst_ = 1'b0;
    always #5 clk = ~clk;

    logic       sv0 = 0, sv1 = 0, sv2 = 0;
    logic [7:0] sd0 = 0, sd1 = 0, sd2 = 0;
    logic [3:0] req0 = 0, req1 = 0, req2 = 0;
    logic       sr0, sr1, sr2, busy0, busy1, busy2, st0, st1, st2;
    logic [3:0] gnt0, gnt1, gnt2;
    logic [7:0] rnd0, rnd1, rnd2;
    int checks = 0, errors = 0;
    logic side_done = 0;

    prn_arbiter u0 (.clk(clk), .rst_(rst_), .seed_valid(sv0), .seed_data(sd0), .seed_ready(sr0),
        .req(req0), .gnt(gnt0), .rnd_data(rnd0), .busy(busy0), .stuck_err(st0));
    prn_arbiter #(.WARMUP(0)) u1 (.clk(clk), .rst_(rst_), .seed_valid(sv1), .seed_data(sd1), .seed_ready(sr1),
        .req(req1), .gnt(gnt1), .rnd_data(rnd1), .busy(busy1), .stuck_err(st1));
    prn_arbiter #(.TAPS(8'h00)) u2 (.clk(clk), .rst_(rst_), .seed_valid(sv2), .seed_data(sd2), .seed_ready(sr2),
        .req(req2), .gnt(gnt2), .rnd_data(rnd2), .busy(busy2), .stuck_err(st2));

    logic [7:0] rr_rnd [6] = '{8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C, 8'h38};
    logic [3:0] rr_gnt [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0] w0_rnd [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    logic [7:0] lk_rnd [6] = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model of u0 (defaults: NREQ=4, TAPS=B8, WARMUP=4).
    function automatic logic [7:0] m_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction
    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) if (r[(p + i) % 4]) return (p + i) % 4;
        return 0;
    endfunction

    logic [7:0] m_lfsr, m_rnd;
    logic [3:0] m_gnt;
    logic       m_warm, m_stuck;
    int         m_left, m_ptr;
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_lfsr <= 8'h01; m_warm <= 1; m_left <= 4; m_ptr <= 0;
            m_gnt <= 0; m_rnd <= 0; m_stuck <= 0;
        end else begin
            m_gnt <= 0;
            m_stuck <= 0;
            if (m_lfsr == 0) begin
                m_lfsr <= 8'h01; m_stuck <= 1;
            end else if (m_warm) begin
                if (m_left > 0) begin m_lfsr <= m_step(m_lfsr); m_left <= m_left - 1; end
                else m_warm <= 0;
            end else if (sv0) begin
                m_lfsr <= (sd0 != 0) ? sd0 : 8'h01;
                m_stuck <= (sd0 == 0);
                m_left <= 4; m_warm <= 1;
            end else if (req0 != 0) begin
                m_gnt <= 4'(1 << pick(req0, m_ptr));
                m_rnd <= m_lfsr;
                m_lfsr <= m_step(m_lfsr);
                m_ptr <= (pick(req0, m_ptr) + 1) % 4;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_gnt", gnt0, m_gnt);
        chk("m_rnd", rnd0, m_rnd);
        chk("m_busy", busy0, m_warm);
        chk("m_seed_ready", sr0, !m_warm);
        chk("m_stuck", st0, m_stuck);
    end

    task automatic warm_count(input string nm);
        int cnt = 0;
        for (int i = 0; i < 20 && busy0; i++) begin cnt++; @(negedge clk); end
        chk(nm, cnt, 5);
    endtask
    task automatic grab(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rr_gnt", gnt0, rr_gnt[k]);
            chk("rr_rnd", rnd0, rr_rnd[k]);
        end
    endtask
    task automatic rst_vals(input string nm);
        chk({nm, "_gnt"}, gnt0, 0);
        chk({nm, "_busy"}, busy0, 1);
        chk({nm, "_rnd"}, rnd0, 0);
        chk({nm, "_stuck"}, st0, 0);
        chk({nm, "_sready"}, sr0, 0);
        chk({nm, "_lfsr"}, u0.lfsr, 8'h01);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_vals("reset");
        rst_ = 1; req0 = 4'hF;
        warm_count("warm_len");
        grab(6);
        req0 = 0;
        @(negedge clk);
        chk("drop_gnt", gnt0, 0);
        chk("drop_rnd_hold", rnd0, 8'h38);
        sv0 = 1; sd0 = 8'h00; req0 = 4'b0010;
        @(negedge clk);
        sv0 = 0;
        chk("zseed_nognt", gnt0, 0);
        chk("zseed_stuck", st0, 1);
        chk("zseed_lfsr", u0.lfsr, 8'h01);
        warm_count("zseed_warm");
        @(negedge clk);
        chk("zseed_gnt", gnt0, 4'b0010);
        chk("zseed_rnd", rnd0, 8'h11);
        chk("zseed_stuck_gone", st0, 0);
        sv0 = 1; sd0 = 8'h5A; req0 = 4'b0100;
        @(negedge clk);
        sv0 = 0;
        chk("seed_nognt", gnt0, 0);
        chk("seed_busy", busy0, 1);
        warm_count("seed_warm");
        @(negedge clk);
        chk("seed_gnt", gnt0, 4'b0100);
        chk("seed_rnd", rnd0, 8'hA4);
        req0 = 0;
        for (int i = 0; i < 100 && !side_done; i++) @(negedge clk);
        chk("side_done", side_done, 1);
        sv0 = 1; sd0 = 8'h33;
        @(negedge clk);
        sv0 = 0;
        @(negedge clk);
        #2 rst_ = 0;
        #1 rst_vals("rst_warm");
        @(negedge clk);
        rst_ = 1; req0 = 4'hF;
        warm_count("rewarm1");
        grab(1);
        #2 rst_ = 0;
        #1 rst_vals("rst_gnt");
        @(negedge clk);
        rst_ = 1;
        warm_count("rewarm2");
        grab(2);
        req0 = 0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        @(posedge rst_);
        fork
            begin
                int got = 0, first = 0, last = 0;
                for (int i = 0; i < 10 && !sr1; i++) @(negedge clk);
                chk("w0_ready", sr1, 1);
                sv1 = 1; sd1 = 8'h01;
                @(negedge clk);
                sv1 = 0;
                chk("w0_busy", busy1, 1);
                req1 = 4'b0001;
                for (int c = 0; c < 20 && got < 6; c++) begin
                    @(negedge clk);
                    if (gnt1 != 0) begin
                        chk("w0_gnt", gnt1, 4'b0001);
                        chk("w0_rnd", rnd1, w0_rnd[got]);
                        if (got == 0) first = c;
                        last = c;
                        got++;
                        if (got == 6) req1 = 0;
                    end
                end
                chk("w0_count", got, 6);
                chk("w0_back2back", last - first, 5);
            end
            begin
                int got = 0, nst = 0;
                req2 = 4'b0001;
                for (int c = 0; c < 40 && got < 6; c++) begin
                    @(negedge clk);
                    if (st2) begin
                        nst++;
                        chk("lock_nognt", gnt2, 0);
                    end
                    if (gnt2 != 0) begin
                        chk("lock_rnd", rnd2, lk_rnd[got]);
                        got++;
                    end
                end
                req2 = 0;
                chk("lock_count", got, 6);
                chk("lock_pulses", nst, 1);
            end
        join
        side_done = 1;
    end
endmodule
